// File: rtl/andor_pkg.sv
// -----------------------------------------------------------------------------
// andor_pkg
// Shared definitions for the AND-OR gate vector generator and its bench:
//   - state_t      : run-control FSM states
//   - NUM_VECTORS  : number of distinct {A,B,C,D} input combinations
//   - VEC_W        : width of one vector / of the vector index
//   - andor_expect : golden function of the gate, Y = A&B | C&D
// -----------------------------------------------------------------------------
package andor_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Vector bit 3 is A, bit 0 is D.
    function automatic logic andor_expect(input logic [VEC_W-1:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

endpackage

// File: rtl/andor_vector_gen.sv
// -----------------------------------------------------------------------------
// andor_vector_gen
// Stimulus and checking stage for the 4-input AND-OR gate. On start it walks
// all 16 {a,b,c,d} combinations beginning at START_VEC (wrapping mod 16),
// offering each one with valid/ready, drives the expected gate output with
// it, and counts how often the returned y_in disagrees on a transfer.
//
// Parameters
//   START_VEC  : first vector index (0..15)
//   GAP_CYCLES : valid-low cycles inserted after each transfer (0..15)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   begin a 16-vector run (only honoured in IDLE)
//   abort    in   drop the current run, back to IDLE next cycle
//   ready    in   consumer accepts the presented vector
//   y_in     in   gate output for the presented vector
//   a,b,c,d  out  presented vector, a = bit 3 ... d = bit 0
//   valid    out  a/b/c/d/exp_y hold a live vector
//   exp_y    out  expected gate output for the presented vector
//   vec_idx  out  index of the presented vector
//   busy     out  run in progress (RUN, GAP or DONE)
//   done     out  single-cycle pulse when a run completes
//   err_cnt  out  mismatching transfers in the current/last run
// -----------------------------------------------------------------------------
module andor_vector_gen
    import andor_pkg::*;
#(
    parameter int START_VEC  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             valid,
    output logic             exp_y,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic [4:0]       err_cnt
);

    localparam logic [VEC_W-1:0] START_IDX = START_VEC[VEC_W-1:0];
    // Gap counter is preloaded so that it expires after GAP_CYCLES cycles.
    localparam logic [3:0]       GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    // Transfer count just before the final (16th) transfer.
    localparam logic [4:0]       LAST_XFER = 5'(NUM_VECTORS - 1);

    state_t           state_reg, state_next;
    logic [VEC_W-1:0] vec_reg, vec_next;
    logic             exp_y_reg, exp_y_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [4:0]       err_reg, err_next;
    logic [4:0]       xfer_reg, xfer_next;
    logic [3:0]       gap_reg, gap_next;

    logic             xfer;
    logic             mismatch;
    logic [VEC_W-1:0] vec_inc;

    assign xfer     = (state_reg == RUN) && valid_reg && ready;
    assign mismatch = (y_in != exp_y_reg);
    assign vec_inc  = vec_reg + 1'b1;   // natural 4-bit wrap 15 -> 0

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        exp_y_next = exp_y_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        xfer_next  = xfer_reg;
        gap_next   = gap_reg;

        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                busy_next  = 1'b0;
                // abort together with start suppresses the start.
                if (start && !abort) begin
                    state_next = RUN;
                    vec_next   = START_IDX;
                    exp_y_next = andor_expect(START_IDX);
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    err_next   = 5'd0;
                    xfer_next  = 5'd0;
                end
            end
            RUN: begin
                if (xfer) begin
                    err_next  = err_reg + {4'd0, mismatch};
                    xfer_next = xfer_reg + 5'd1;
                    if (xfer_reg == LAST_XFER) begin
                        // Completion is by transfer count, never by index.
                        state_next = DONE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        vec_next   = vec_inc;
                        exp_y_next = andor_expect(vec_inc);
                    end else begin
                        state_next = GAP;
                        valid_next = 1'b0;
                        gap_next   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                // Vector outputs keep the last transferred value while idle.
                if (gap_reg == 4'd0) begin
                    state_next = RUN;
                    valid_next = 1'b1;
                    vec_next   = vec_inc;
                    exp_y_next = andor_expect(vec_inc);
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase

        // Abort overrides the state move but leaves err_next alone, so a
        // transfer on the same edge is still scored.
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            exp_y_reg <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 5'd0;
            xfer_reg  <= 5'd0;
            gap_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            exp_y_reg <= exp_y_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            xfer_reg  <= xfer_next;
            gap_reg   <= gap_next;
        end
    end

    assign {a, b, c, d} = vec_reg;
    assign vec_idx      = vec_reg;
    assign exp_y        = exp_y_reg;
    assign valid        = valid_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err_cnt      = err_reg;

endmodule

// File: tb/tb_andor_vector_gen.sv
// -----------------------------------------------------------------------------
// tb_andor_vector_gen
// Two generator instances: A (START_VEC=0, GAP_CYCLES=0) exercised with
// table-driven runs and hand-written abort/reset sequences; B (START_VEC=14,
// GAP_CYCLES=2) exercised with forced-zero and randomised ready/y_in runs
// scored against a transfer-level reference (k-th transfer carries index
// (START+k) mod 16, expected Y taken from a constant truth mask).
// -----------------------------------------------------------------------------
module tb_andor_vector_gen;
    import andor_pkg::*;

    // Truth table of Y = A&B | C&D over index 0..15: ones at 3,7,11,12..15.
    localparam logic [15:0] EXP_MASK = 16'hF888;
    localparam int          B_START  = 14;
    localparam int          B_GAP    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT A ----------------
    logic       rst_n_a, start_a, abort_a, ready_a, inj_a, y_in_a;
    logic       a_a, b_a, c_a, d_a, valid_a, exp_y_a, busy_a, done_a;
    logic [3:0] vec_idx_a;
    logic [4:0] err_cnt_a;

    // Correct gate model, optionally inverted to inject a mismatch.
    assign y_in_a = ((a_a & b_a) | (c_a & d_a)) ^ inj_a;

    andor_vector_gen #(.START_VEC(0), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
        .ready(ready_a), .y_in(y_in_a),
        .a(a_a), .b(b_a), .c(c_a), .d(d_a), .valid(valid_a), .exp_y(exp_y_a),
        .vec_idx(vec_idx_a), .busy(busy_a), .done(done_a), .err_cnt(err_cnt_a)
    );

    // ---------------- DUT B ----------------
    logic       rst_n_b, start_b, abort_b, ready_b, y_in_b;
    logic       a_b, b_b, c_b, d_b, valid_b, exp_y_b, busy_b, done_b;
    logic [3:0] vec_idx_b;
    logic [4:0] err_cnt_b;

    andor_vector_gen #(.START_VEC(B_START), .GAP_CYCLES(B_GAP)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
        .ready(ready_b), .y_in(y_in_b),
        .a(a_b), .b(b_b), .c(c_b), .d(d_b), .valid(valid_b), .exp_y(exp_y_b),
        .vec_idx(vec_idx_b), .busy(busy_b), .done(done_b), .err_cnt(err_cnt_b)
    );

    typedef struct {
        logic       ready;
        logic       inj;
        logic [3:0] idx;
        logic       exp_y;
    } vec_row_t;

    vec_row_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply tbl to DUT A one cycle per row, checking the presented vector.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            ready_a = tbl[i].ready;
            inj_a   = tbl[i].inj;
            check({tag, " valid"}, valid_a, 1'b1);
            check({tag, " busy"}, busy_a, 1'b1);
            check({tag, " vec_idx"}, vec_idx_a, tbl[i].idx);
            check({tag, " abcd"}, {a_a, b_a, c_a, d_a}, tbl[i].idx);
            check({tag, " exp_y"}, exp_y_a, tbl[i].exp_y);
            if (tbl[i].ready)
                $display("[TB] %s xfer idx=%0d exp_y=%0d", tag, vec_idx_a, exp_y_a);
            else
                $display("[TB] %s stall idx=%0d", tag, vec_idx_a);
            tick();
        end
        ready_a = 1'b1;
        inj_a   = 1'b0;
    endtask

    // One full run on DUT B scored at transfer level.
    task automatic run_b(input bit rnd, input string tag);
        int         k, low, errs, cyc;
        bit         pend, finished;
        logic [3:0] exp_idx;
        k = 0; low = 0; errs = 0; cyc = 0; pend = 0; finished = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (!finished && cyc < 400) begin
            cyc++;
            ready_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            y_in_b  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done_b) begin
                finished = 1;
                check({tag, " transfers"}, k, 16);
                check({tag, " err_cnt"}, err_cnt_b, errs);
                check({tag, " valid at done"}, valid_b, 1'b0);
                check({tag, " busy at done"}, busy_b, 1'b1);
            end else if (valid_b) begin
                exp_idx = 4'((B_START + k) % NUM_VECTORS);
                if (pend) begin
                    check({tag, " gap length"}, low, B_GAP);
                    pend = 0;
                end
                check({tag, " vec_idx"}, vec_idx_b, exp_idx);
                check({tag, " exp_y"}, exp_y_b, EXP_MASK[exp_idx]);
                if (ready_b) begin
                    if (y_in_b != EXP_MASK[exp_idx]) errs++;
                    $display("[TB] %s xfer #%0d idx=%0d y_in=%0d", tag, k, vec_idx_b, y_in_b);
                    k++;
                    pend = 1;
                    low  = 0;
                end
            end else begin
                low++;
            end
            tick();
        end
        ready_b = 1'b0;
        y_in_b  = 1'b0;
        if (!finished) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s timeout: got %0d transfers, expected done", tag, k);
        end else begin
            check({tag, " done cleared"}, done_b, 1'b0);
            check({tag, " busy cleared"}, busy_b, 1'b0);
        end
    endtask

    initial begin
        rst_n_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1; inj_a = 1'b0;
        rst_n_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0; y_in_b = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst valid", valid_a, 1'b0);
        check("rst busy", busy_a, 1'b0);
        check("rst done", done_a, 1'b0);
        check("rst err_cnt", err_cnt_a, 5'd0);
        check("rst vec_idx", vec_idx_a, 4'd0);
        check("rst exp_y", exp_y_a, 1'b0);
        check("rst B valid", valid_b, 1'b0);
        check("rst B busy", busy_b, 1'b0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Shared golden function against the truth mask
        for (int i = 0; i < NUM_VECTORS; i++)
            check("andor_expect", andor_expect(4'(i)), EXP_MASK[i]);

        // abort + start in IDLE: start ignored, abort harmless
        abort_a = 1'b1; start_a = 1'b1;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        check("idle abort+start valid", valid_a, 1'b0);
        check("idle abort+start busy", busy_a, 1'b0);

        // Full run, correct gate, ready tied high
        tbl.delete();
        for (int i = 0; i < NUM_VECTORS; i++)
            tbl.push_back('{ready: 1'b1, inj: 1'b0, idx: 4'(i), exp_y: EXP_MASK[i]});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_table("full");
        check("full done", done_a, 1'b1);
        check("full valid at done", valid_a, 1'b0);
        check("full busy at done", busy_a, 1'b1);
        check("full err_cnt", err_cnt_a, 5'd0);
        start_a = 1'b1;                      // ignored in DONE
        tick();
        check("post-done done", done_a, 1'b0);
        check("post-done busy", busy_a, 1'b0);
        check("start in DONE ignored", valid_a, 1'b0);
        check("err_cnt held", err_cnt_a, 5'd0);
        tick();                              // start sampled in IDLE: accepted
        start_a = 1'b0;

        // Backpressure at idx 5 for 3 cycles
        tbl.delete();
        for (int i = 0; i < NUM_VECTORS; i++) begin
            if (i == 5)
                for (int s = 0; s < 3; s++)
                    tbl.push_back('{ready: 1'b0, inj: 1'b0, idx: 4'(i), exp_y: EXP_MASK[i]});
            tbl.push_back('{ready: 1'b1, inj: 1'b0, idx: 4'(i), exp_y: EXP_MASK[i]});
        end
        run_table("bp");
        check("bp done", done_a, 1'b1);
        check("bp err_cnt", err_cnt_a, 5'd0);
        tick();
        check("bp idle busy", busy_a, 1'b0);

        // Abort after 4 transfers with one mismatch; start during abort ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ready_a = 1'b1;
            inj_a   = (i == 1);
            check("abort run vec_idx", vec_idx_a, 4'(i));
            $display("[TB] abort-run xfer idx=%0d inj=%0d", vec_idx_a, inj_a);
            tick();
        end
        inj_a = 1'b0; abort_a = 1'b1; start_a = 1'b1;
        tick();
        abort_a = 1'b0; start_a = 1'b0;
        check("abort valid", valid_a, 1'b0);
        check("abort busy", busy_a, 1'b0);
        check("abort no done", done_a, 1'b0);
        check("abort err_cnt", err_cnt_a, 5'd1);
        tick();
        check("abort start ignored", valid_a, 1'b0);
        check("abort no late done", done_a, 1'b0);
        check("abort err frozen", err_cnt_a, 5'd1);

        // Abort on the same edge as a mismatching transfer: still counted
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("restart err cleared", err_cnt_a, 5'd0);
        check("restart vec_idx", vec_idx_a, 4'd0);
        ready_a = 1'b1; inj_a = 1'b1; abort_a = 1'b1;
        tick();
        inj_a = 1'b0; abort_a = 1'b0;
        check("abort+xfer busy", busy_a, 1'b0);
        check("abort+xfer err_cnt", err_cnt_a, 5'd1);

        // Reset mid-run at vector 9
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ready_a = 1'b1;
            inj_a   = (i == 2);
            tick();
        end
        inj_a = 1'b0;
        check("pre-reset vec_idx", vec_idx_a, 4'd9);
        check("pre-reset err_cnt", err_cnt_a, 5'd1);
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        check("mid rst valid", valid_a, 1'b0);
        check("mid rst busy", busy_a, 1'b0);
        check("mid rst done", done_a, 1'b0);
        check("mid rst err_cnt", err_cnt_a, 5'd0);
        check("mid rst vec_idx", vec_idx_a, 4'd0);
        check("mid rst abcd", {a_a, b_a, c_a, d_a}, 4'd0);
        check("mid rst exp_y", exp_y_a, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("post rst valid", valid_a, 1'b1);
        check("post rst vec_idx", vec_idx_a, 4'd0);
        check("post rst err_cnt", err_cnt_a, 5'd0);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;

        // DUT B: wrap from 14, 2-cycle gaps, y_in forced 0
        run_b(1'b0, "gap");
        check("gap err_cnt = ones", err_cnt_b, 5'd7);
        tick();
        check("gap err_cnt held", err_cnt_b, 5'd7);

        // DUT B: randomised ready and y_in
        for (int r = 0; r < 3; r++)
            run_b(1'b1, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
